// File: rtl/booth_seq_ctrl_if.sv
// Operand/result handshake and external adder bus for booth_seq_ctrl.
// The master side is the operand source, the product consumer and the adder; the slave side is the sequencer.
interface booth_seq_ctrl_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   logic [WIDTH:0]       add_a;
   logic [WIDTH:0]       add_b;
   logic                 add_cin;
   logic [WIDTH:0]       add_sum;

   modport master (
      output start, multiplicand, multiplier, add_sum,
      input  busy, done, product, add_a, add_b, add_cin
   );

   modport slave (
      input  start, multiplicand, multiplier, add_sum,
      output busy, done, product, add_a, add_b, add_cin
   );
endinterface

// File: rtl/booth_seq_ctrl.sv
// Radix-2 signed Booth sequencer that uses one external WIDTH+1-bit adder; done comes WIDTH+1 edges after start.
// Optional BOOTH_ZERO_SKIP_EN: a zero operand goes straight to DONE with product 0.
module booth_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   booth_seq_ctrl_if.slave ctrl
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [WIDTH:0]       acc_q, acc_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic                 q1_q, q1_d;
   logic [WIDTH:0]       m_q, m_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [WIDTH:0]       add_a, add_b;
   logic                 add_cin;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         m_q     <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      q_d     = q_q;
      q1_d    = q1_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ctrl.start) begin
               acc_d = '0;
               q_d   = ctrl.multiplier;
               q1_d  = 1'b0;
               m_d   = {ctrl.multiplicand[WIDTH-1], ctrl.multiplicand};
               cnt_d = CW'(WIDTH);
`ifdef BOOTH_ZERO_SKIP_EN
               if (ctrl.multiplicand == '0 || ctrl.multiplier == '0) begin
                  state_d = S_DONE;
                  prod_d  = '0;
               end else begin
                  state_d = S_RUN;
               end
`else
               state_d = S_RUN;
`endif
            end
         end
         S_RUN: begin
            add_a = acc_q;
            case ({q_q[0], q1_q})
               2'b01: add_b = m_q;
               2'b10: begin
                  add_b   = ~m_q;
                  add_cin = 1'b1;
               end
               default: add_b = '0;
            endcase
            // Arithmetic shift of {sum, Q, Q_1}; the extra accumulator bit keeps -2^(W-1) squared in range.
            acc_d = {ctrl.add_sum[WIDTH], ctrl.add_sum[WIDTH:1]};
            q_d   = {ctrl.add_sum[0], q_q[WIDTH-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = S_DONE;
               prod_d  = {acc_d[WIDTH-1:0], q_d};
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign ctrl.busy    = (state_q != S_IDLE);
   assign ctrl.done    = (state_q == S_DONE);
   assign ctrl.product = prod_q;
   assign ctrl.add_a   = add_a;
   assign ctrl.add_b   = add_b;
   assign ctrl.add_cin = add_cin;
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: it models the external adder, applies fixed vectors, corner sequences and random pairs,
// and compares every result with the plain signed product.
module tb_booth_seq_ctrl;
   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   booth_seq_ctrl_if #(.WIDTH(W)) bus ();

   booth_seq_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (bus)
   );

   assign bus.add_sum = bus.add_a + bus.add_b + {{W{1'b0}}, bus.add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] exp;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      int sa;
      int sb;
      int p;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      return p[2*W-1:0];
   endfunction

   function automatic int ref_edges(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef BOOTH_ZERO_SKIP_EN
      if (a == '0 || b == '0) return 1;
`endif
      return W + 1;
   endfunction

   // One multiplication; edges are counted with the accepting edge as 1.
   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] exp,
                          input bit disturb, input string name);
      int edges;
      @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplicand = a;
      bus.multiplier   = b;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      bus.start = 1'b0;
      if (disturb) begin
         bus.start        = 1'b1;
         bus.multiplicand = 8'h09;
         bus.multiplier   = 8'h09;
      end
      while (!bus.done && edges < 40) begin
         chk({name, "_busy_run"}, {31'd0, bus.busy}, 32'd1);
         @(posedge clk);
         edges++;
         @(negedge clk);
         bus.start = 1'b0;
      end
      chk({name, "_edges"}, edges, ref_edges(a, b));
      chk({name, "_product"}, {16'd0, bus.product}, {16'd0, exp});
      chk({name, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
      chk({name, "_adder_idle"}, {bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
      chk({name, "_busy_idle"}, {31'd0, bus.busy}, 32'd0);
      chk({name, "_hold"}, {16'd0, bus.product}, {16'd0, exp});
   endtask

   vec_t tbl[6];

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           edges;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.start        = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;

      tbl[0] = '{8'h03, 8'h05, 16'h000F};
      tbl[1] = '{8'h80, 8'h80, 16'h4000};
      tbl[2] = '{8'h7F, 8'hFF, 16'hFF81};
      tbl[3] = '{8'hF9, 8'h06, 16'hFFD6};
      tbl[4] = '{8'h00, 8'h37, 16'h0000};
      tbl[5] = '{8'hFF, 8'hFF, 16'h0001};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_product", {16'd0, bus.product}, 32'd0);
      chk("rst_adder", {bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
      rst_n = 1'b1;

      // First Booth step of 3 x 5 sees pair {1,0}: subtract M.
      @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplicand = 8'h03;
      bus.multiplier   = 8'h05;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      chk("step1_add_a", {23'd0, bus.add_a}, 32'd0);
      chk("step1_add_b", {23'd0, bus.add_b}, 32'h1FC);
      chk("step1_cin", {31'd0, bus.add_cin}, 32'd1);
      edges = 1;
      while (!bus.done && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      chk("step1_product", {16'd0, bus.product}, 32'h000F);

      for (int i = 0; i < 6; i++)
         run_mul(tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0, $sformatf("vec%0d", i));

      run_mul(8'h03, 8'h05, 16'h000F, 1'b1, "start_in_run");

      // Back-to-back with start held: second operands accepted in the IDLE cycle after DONE.
      @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplicand = 8'h02;
      bus.multiplier   = 8'h03;
      edges = 0;
      while (!bus.done && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      chk("b2b_first", {16'd0, bus.product}, 32'h0006);
      bus.multiplicand = 8'h04;
      bus.multiplier   = 8'h05;
      @(posedge clk);
      @(negedge clk);
      chk("b2b_idle_gap", {31'd0, bus.busy}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("b2b_reaccept", {31'd0, bus.busy}, 32'd1);
      bus.start = 1'b0;
      edges = 0;
      while (!bus.done && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      chk("b2b_second", {16'd0, bus.product}, 32'h0014);

      // Reset during step 4 of 12 x 12.
      @(posedge clk);
      @(negedge clk);
      bus.start        = 1'b1;
      bus.multiplicand = 8'd12;
      bus.multiplier   = 8'd12;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_done", {31'd0, bus.done}, 32'd0);
      chk("midrst_product", {16'd0, bus.product}, 32'd0);
      chk("midrst_adder", {bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
      rst_n = 1'b1;
      run_mul(8'h02, 8'h02, 16'h0004, 1'b0, "after_rst");

      for (int i = 0; i < 1500; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 50 == 0) ra = 8'h80;
         run_mul(ra, rb, ref_mul(ra, rb), 1'b0, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
